// File: rtl/issue_unit.sv
// Dual-issue hazard unit. Sits between the decode/issue register and execute.
// Each cycle it decides which of the two slots go forward, zeroes the rest,
// and asks the frontend to hold when a slot still has to be issued later.
// Load-use hazards are tracked with a one-entry tag naming the destination
// of the youngest load that went forward on the previous advancing edge.

// Per-slot output gate: a slot that is not forwarded becomes an all-zero NOP.
module issue_slot #(
  parameter int CTRL_W = 16
) (
  input  logic              i_fwd,
  input  logic [31:0]       i_inst,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_pred,
  input  logic [31:0]       i_tgt,
  output logic [31:0]       o_inst,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_pred,
  output logic [31:0]       o_tgt
);
  assign o_inst = i_fwd ? i_inst : '0;
  assign o_ctrl = i_fwd ? i_ctrl : '0;
  assign o_pred = i_fwd & i_pred;
  assign o_tgt  = i_fwd ? i_tgt  : '0;
endmodule

module issue_unit #(
  parameter int CTRL_W = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [31:0]       inst0_i,
  input  logic [31:0]       inst1_i,
  input  logic [CTRL_W-1:0] ctrl0_i,
  input  logic [CTRL_W-1:0] ctrl1_i,
  input  logic              pred_0_i,
  input  logic              pred_1_i,
  input  logic [31:0]       pred_tgt_0_i,
  input  logic [31:0]       pred_tgt_1_i,
  input  logic              rd_we0_i,
  input  logic              rd_we1_i,
  input  logic              use_rs1_0_i,
  input  logic              use_rs2_0_i,
  input  logic              use_rs1_1_i,
  input  logic              use_rs2_1_i,
  input  logic              mem0_i,
  input  logic              mem1_i,
  input  logic              load0_i,
  input  logic              load1_i,
  input  logic              backend_we_i,
  input  logic              flush_i,
  output logic [31:0]       issued_inst0_o,
  output logic [31:0]       issued_inst1_o,
  output logic [CTRL_W-1:0] issued_ctrl0_o,
  output logic [CTRL_W-1:0] issued_ctrl1_o,
  output logic              issued_pred_0_o,
  output logic              issued_pred_1_o,
  output logic [31:0]       issued_pred_tgt_0_o,
  output logic [31:0]       issued_pred_tgt_1_o,
  output logic              hold_o
);
  localparam int NUM_SLOTS = 2;

  typedef enum logic [1:0] {S_PAIR, S_SECOND, S_BUBBLE} state_t;

  state_t     r_state, w_next;
  logic       r_tag_vld, w_tag_vld_nx;
  logic [4:0] r_tag_rd, w_tag_rd_nx;
  // Set when a BUBBLE was entered from SECOND, so slot 1 still owes an issue.
  logic       r_ret_second, w_ret_nx;

  logic [NUM_SLOTS-1:0]             w_fwd;
  logic                             w_hold;
  logic [4:0] w_rd0, w_rs1_0, w_rs2_0, w_rd1, w_rs1_1, w_rs2_1;
  logic       w_raw, w_waw, w_conflict, w_lu0, w_lu1;

  assign w_rd0   = inst0_i[11:7];
  assign w_rs1_0 = inst0_i[19:15];
  assign w_rs2_0 = inst0_i[24:20];
  assign w_rd1   = inst1_i[11:7];
  assign w_rs1_1 = inst1_i[19:15];
  assign w_rs2_1 = inst1_i[24:20];

  // Intra-pair hazards; x0 never creates a dependency.
  assign w_raw = rd_we0_i && (w_rd0 != 5'd0) &&
                 ((use_rs1_1_i && (w_rs1_1 == w_rd0)) ||
                  (use_rs2_1_i && (w_rs2_1 == w_rd0)));
  assign w_waw = rd_we0_i && rd_we1_i && (w_rd0 != 5'd0) && (w_rd0 == w_rd1);
  assign w_conflict = w_raw || w_waw || (mem0_i && mem1_i) || pred_0_i;

  // Load-use against the load tag, per slot.
  assign w_lu0 = r_tag_vld &&
                 ((use_rs1_0_i && (w_rs1_0 != 5'd0) && (w_rs1_0 == r_tag_rd)) ||
                  (use_rs2_0_i && (w_rs2_0 != 5'd0) && (w_rs2_0 == r_tag_rd)));
  assign w_lu1 = r_tag_vld &&
                 ((use_rs1_1_i && (w_rs1_1 != 5'd0) && (w_rs1_1 == r_tag_rd)) ||
                  (use_rs2_1_i && (w_rs2_1 != 5'd0) && (w_rs2_1 == r_tag_rd)));

  // Issue decision, next state and the next load tag.
  always_comb begin
    w_fwd    = '0;
    w_hold   = 1'b0;
    w_next   = r_state;
    w_ret_nx = r_ret_second;
    unique case (r_state)
      S_PAIR: begin
        if (w_lu0 || w_lu1) begin
          w_hold   = 1'b1;
          w_next   = S_BUBBLE;
          w_ret_nx = 1'b0;
        end else if (w_conflict) begin
          w_fwd[0] = 1'b1;
          // A predicted-taken slot 0 makes slot 1 wrong-path: drop it outright.
          if (!pred_0_i) begin
            w_hold = 1'b1;
            w_next = S_SECOND;
          end
        end else begin
          w_fwd = '1;
        end
      end
      S_SECOND: begin
        if (w_lu1) begin
          w_hold   = 1'b1;
          w_next   = S_BUBBLE;
          w_ret_nx = 1'b1;
        end else begin
          w_fwd[1] = 1'b1;
          w_next   = S_PAIR;
        end
      end
      S_BUBBLE: begin
        w_next   = r_ret_second ? S_SECOND : S_PAIR;
        w_ret_nx = 1'b0;
      end
      default: w_next = S_PAIR;
    endcase
    // While in reset the unit behaves as an unhindered pair.
    if (reset_i) begin
      w_fwd  = '1;
      w_hold = 1'b0;
    end
    if (flush_i) w_hold = 1'b0;
    // Youngest forwarded load wins; nothing forwarded clears the tag.
    w_tag_vld_nx = 1'b0;
    w_tag_rd_nx  = 5'd0;
    if (w_fwd[1] && load1_i && (w_rd1 != 5'd0)) begin
      w_tag_vld_nx = 1'b1;
      w_tag_rd_nx  = w_rd1;
    end else if (w_fwd[0] && load0_i && (w_rd0 != 5'd0)) begin
      w_tag_vld_nx = 1'b1;
      w_tag_rd_nx  = w_rd0;
    end
  end

  // State and load tag advance only with the backend; flush overrides.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_PAIR;
      r_tag_vld    <= 1'b0;
      r_tag_rd     <= 5'd0;
      r_ret_second <= 1'b0;
    end else if (flush_i) begin
      r_state      <= S_PAIR;
      r_tag_vld    <= 1'b0;
      r_tag_rd     <= 5'd0;
      r_ret_second <= 1'b0;
    end else if (backend_we_i) begin
      r_state      <= w_next;
      r_tag_vld    <= w_tag_vld_nx;
      r_tag_rd     <= w_tag_rd_nx;
      r_ret_second <= w_ret_nx;
    end
  end

  logic [NUM_SLOTS-1:0][31:0]       w_inst, w_tgt, w_oinst, w_otgt;
  logic [NUM_SLOTS-1:0][CTRL_W-1:0] w_ctrl, w_octrl;
  logic [NUM_SLOTS-1:0]             w_pred, w_opred;

  assign w_inst = {inst1_i, inst0_i};
  assign w_tgt  = {pred_tgt_1_i, pred_tgt_0_i};
  assign w_ctrl = {ctrl1_i, ctrl0_i};
  assign w_pred = {pred_1_i, pred_0_i};

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    issue_slot #(.CTRL_W(CTRL_W)) u_slot (
      .i_fwd  (w_fwd[g]),
      .i_inst (w_inst[g]),
      .i_ctrl (w_ctrl[g]),
      .i_pred (w_pred[g]),
      .i_tgt  (w_tgt[g]),
      .o_inst (w_oinst[g]),
      .o_ctrl (w_octrl[g]),
      .o_pred (w_opred[g]),
      .o_tgt  (w_otgt[g])
    );
  end

  assign issued_inst0_o      = w_oinst[0];
  assign issued_inst1_o      = w_oinst[1];
  assign issued_ctrl0_o      = w_octrl[0];
  assign issued_ctrl1_o      = w_octrl[1];
  assign issued_pred_0_o     = w_opred[0];
  assign issued_pred_1_o     = w_opred[1];
  assign issued_pred_tgt_0_o = w_otgt[0];
  assign issued_pred_tgt_1_o = w_otgt[1];
  assign hold_o              = w_hold;
endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: a table of per-cycle vectors with
// hand-computed forward/hold expectations, then an async reset sequence.
module tb_issue_unit;
  localparam int CTRL_W = 16;

  localparam int F_WE0 = 1,    F_WE1 = 2,    F_R10 = 4,    F_R20 = 8;
  localparam int F_R11 = 16,   F_R21 = 32,   F_M0  = 64,   F_M1  = 128;
  localparam int F_L0  = 256,  F_L1  = 512,  F_P0  = 1024, F_P1  = 2048;
  localparam int F_STALL = 4096, F_FL = 8192;

  typedef struct {
    string       nm;
    logic [31:0] i0, i1;
    int          f;
    logic        e0, e1, eh;
  } vec_t;

  logic              clk, rst;
  logic [31:0]       inst0, inst1, tgt0, tgt1;
  logic [CTRL_W-1:0] ctrl0, ctrl1;
  logic              p0, p1, we0, we1, r10, r20, r11, r21, m0, m1, l0, l1, bwe, fl;
  logic [31:0]       o_i0, o_i1, o_t0, o_t1;
  logic [CTRL_W-1:0] o_c0, o_c1;
  logic              o_p0, o_p1, hold;

  int ntests = 0;
  int nfail  = 0;

  issue_unit #(.CTRL_W(CTRL_W)) dut (
    .clock_i(clk), .reset_i(rst),
    .inst0_i(inst0), .inst1_i(inst1), .ctrl0_i(ctrl0), .ctrl1_i(ctrl1),
    .pred_0_i(p0), .pred_1_i(p1), .pred_tgt_0_i(tgt0), .pred_tgt_1_i(tgt1),
    .rd_we0_i(we0), .rd_we1_i(we1),
    .use_rs1_0_i(r10), .use_rs2_0_i(r20), .use_rs1_1_i(r11), .use_rs2_1_i(r21),
    .mem0_i(m0), .mem1_i(m1), .load0_i(l0), .load1_i(l1),
    .backend_we_i(bwe), .flush_i(fl),
    .issued_inst0_o(o_i0), .issued_inst1_o(o_i1),
    .issued_ctrl0_o(o_c0), .issued_ctrl1_o(o_c1),
    .issued_pred_0_o(o_p0), .issued_pred_1_o(o_p1),
    .issued_pred_tgt_0_o(o_t0), .issued_pred_tgt_1_o(o_t1),
    .hold_o(hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rinst(input int rd, input int rs1, input int rs2);
    logic [4:0] a, b, c;
    a = rd[4:0]; b = rs1[4:0]; c = rs2[4:0];
    return {7'd0, c, b, 3'd0, a, 7'h33};
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] i0, input logic [31:0] i1,
                              input int f, input logic e0, input logic e1, input logic eh);
    vec_t v;
    v.nm = nm; v.i0 = i0; v.i1 = i1; v.f = f; v.e0 = e0; v.e1 = e1; v.eh = eh;
    return v;
  endfunction

  task automatic drive(input vec_t v, input int idx);
    inst0 = v.i0; inst1 = v.i1;
    ctrl0 = CTRL_W'(32'hA000 + idx); ctrl1 = CTRL_W'(32'hB000 + idx);
    tgt0  = 32'h1000_0000 + idx;     tgt1  = 32'h2000_0000 + idx;
    we0 = (v.f & F_WE0) != 0; we1 = (v.f & F_WE1) != 0;
    r10 = (v.f & F_R10) != 0; r20 = (v.f & F_R20) != 0;
    r11 = (v.f & F_R11) != 0; r21 = (v.f & F_R21) != 0;
    m0  = (v.f & F_M0) != 0;  m1  = (v.f & F_M1) != 0;
    l0  = (v.f & F_L0) != 0;  l1  = (v.f & F_L1) != 0;
    p0  = (v.f & F_P0) != 0;  p1  = (v.f & F_P1) != 0;
    bwe = (v.f & F_STALL) == 0;
    fl  = (v.f & F_FL) != 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Expected outputs are the driven inputs gated by the hand-written forward flags.
  task automatic check_vec(input vec_t v);
    chk({v.nm, ".inst0"}, o_i0, v.e0 ? inst0 : 32'd0);
    chk({v.nm, ".inst1"}, o_i1, v.e1 ? inst1 : 32'd0);
    chk({v.nm, ".ctrl0"}, 32'(o_c0), v.e0 ? 32'(ctrl0) : 32'd0);
    chk({v.nm, ".ctrl1"}, 32'(o_c1), v.e1 ? 32'(ctrl1) : 32'd0);
    chk({v.nm, ".pred0"}, 32'(o_p0), 32'(v.e0 & p0));
    chk({v.nm, ".pred1"}, 32'(o_p1), 32'(v.e1 & p1));
    chk({v.nm, ".tgt0"},  o_t0, v.e0 ? tgt0 : 32'd0);
    chk({v.nm, ".tgt1"},  o_t1, v.e1 ? tgt1 : 32'd0);
    chk({v.nm, ".hold"},  32'(hold), 32'(v.eh));
  endtask

  vec_t vt[$];
  vec_t hv;

  initial begin
    int base, rawf, ldf;
    logic [31:0] a1, a2;
    a1   = 32'h0050_0093;  // addi x1,x0,5
    a2   = 32'h0070_0113;  // addi x2,x0,7
    base = F_WE0 | F_WE1 | F_R10 | F_R11;
    rawf = base | F_M0 | F_L0;

    vt.push_back(mk("indep",    a1, a2, base, 1, 1, 0));
    vt.push_back(mk("raw_n",    rinst(3,1,0), rinst(4,3,0), base, 1, 0, 1));
    vt.push_back(mk("raw_n1",   rinst(3,1,0), rinst(4,3,0), base, 0, 1, 0));
    vt.push_back(mk("load5",    rinst(5,1,0), rinst(6,0,0), base | F_M0 | F_L0, 1, 1, 0));
    vt.push_back(mk("lu_nop",   rinst(7,5,0), rinst(8,0,0), base, 0, 0, 1));
    vt.push_back(mk("lu_bub",   rinst(7,5,0), rinst(8,0,0), base, 0, 0, 0));
    vt.push_back(mk("lu_issue", rinst(7,5,0), rinst(8,0,0), base, 1, 1, 0));
    vt.push_back(mk("waw",      rinst(9,1,0), rinst(9,2,0), base, 1, 0, 1));
    vt.push_back(mk("stall1",   rinst(9,1,0), rinst(9,2,0), base | F_STALL, 0, 1, 0));
    vt.push_back(mk("stall2",   rinst(9,1,0), rinst(9,2,0), base | F_STALL, 0, 1, 0));
    vt.push_back(mk("stall3",   rinst(9,1,0), rinst(9,2,0), base | F_STALL, 0, 1, 0));
    vt.push_back(mk("advance",  rinst(9,1,0), rinst(9,2,0), base, 0, 1, 0));
    vt.push_back(mk("pred0",    a1, a2, base | F_P0, 1, 0, 0));
    vt.push_back(mk("pred1",    a1, a2, base | F_P1, 1, 1, 0));
    vt.push_back(mk("mem",      rinst(3,2,4), rinst(10,2,0),
                    F_R10 | F_R20 | F_M0 | F_WE1 | F_R11 | F_M1 | F_L1, 1, 0, 1));
    vt.push_back(mk("fl_stall", rinst(3,2,4), rinst(10,2,0),
                    F_R10 | F_R20 | F_M0 | F_WE1 | F_R11 | F_M1 | F_L1 | F_STALL | F_FL, 0, 1, 0));
    vt.push_back(mk("fl_state", rinst(11,10,0), rinst(12,0,0), base, 1, 1, 0));
    vt.push_back(mk("fl_raw",   rinst(13,1,0), rinst(14,13,0), rawf | F_FL, 1, 0, 0));
    vt.push_back(mk("raw_ld",   rinst(13,1,0), rinst(14,13,0), rawf, 1, 0, 1));
    vt.push_back(mk("lu_sec",   rinst(13,1,0), rinst(14,13,0), rawf, 0, 0, 1));
    vt.push_back(mk("bub_sec",  rinst(13,1,0), rinst(14,13,0), rawf, 0, 0, 0));
    vt.push_back(mk("sec_ret",  rinst(13,1,0), rinst(14,13,0), rawf, 0, 1, 0));
    vt.push_back(mk("x0_dst",   rinst(0,1,0), rinst(0,0,0),
                    base | F_R20 | F_R21 | F_M0 | F_L0, 1, 1, 0));
    vt.push_back(mk("x0_src",   rinst(15,0,0), rinst(16,0,0), base | F_R20 | F_R21, 1, 1, 0));

    // Reset: conflicting pair still forwards both, no hold.
    rst = 1'b1;
    hv = mk("rst_fwd", rinst(3,1,0), rinst(4,3,0), base | F_STALL, 1, 1, 0);
    drive(hv, 99);
    @(negedge clk);
    #1 check_vec(hv);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i], i);
      #1 check_vec(vt[i]);
    end

    // Mid-BUBBLE asynchronous reset.
    @(negedge clk);
    hv = mk("r_load", rinst(5,1,0), rinst(6,0,0), base | F_M0 | F_L0, 1, 1, 0);
    drive(hv, 200);
    #1 check_vec(hv);
    @(negedge clk);
    hv = mk("r_lu", rinst(7,5,0), rinst(8,0,0), base, 0, 0, 1);
    drive(hv, 201);
    #1 check_vec(hv);
    @(negedge clk);
    hv.nm = "r_bubble"; hv.eh = 0;
    #1 check_vec(hv);
    rst = 1'b1;
    hv.nm = "r_during"; hv.e0 = 1; hv.e1 = 1;
    #1 check_vec(hv);
    rst = 1'b0;
    hv.nm = "r_after";
    #1 check_vec(hv);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
